// File: rtl/timer_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : timer_ctrl_pkg
// Description : Shared state encoding and mode constants for timer_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
package timer_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic ONE_SHOT = 1'b0;
    localparam logic PERIODIC = 1'b1;

endpackage
`default_nettype wire

// File: rtl/up_counter_en.sv
`default_nettype none
// ============================================================================
// Module      : up_counter_en
// Description : WIDTH-bit up counter with enable and synchronous clear.
// Revision    : 1.0 - initial release
// ============================================================================
module up_counter_en
    import timer_ctrl_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_q;

    // Clear takes priority over enable.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_q <= '0;
        end else if (clr) begin
            r_q <= '0;
        end else if (en) begin
            r_q <= r_q + WIDTH'(1);
        end
    end

    assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/timer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : timer_ctrl
// Description : Prescaled one-shot / periodic timer with pause and sticky irq.
// Revision    : 1.0 - initial release
// ============================================================================
module timer_ctrl
    import timer_ctrl_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int PSW   = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             mode,
    input  logic [WIDTH-1:0] period,
    input  logic [PSW-1:0]   prescale,
    input  logic             irq_clr,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             tc,
    output logic             irq
);

    state_t           r_state;
    logic             r_mode;
    logic [WIDTH-1:0] r_period;
    logic [PSW-1:0]   r_prescale;
    logic             r_tc;
    logic             r_irq;
    logic             r_busy;

    logic [WIDTH-1:0] w_count;
    logic [PSW-1:0]   w_psc;
    logic             w_step;
    logic             w_tick;
    logic             w_term;
    logic             w_cnt_clr;
    logic             w_cnt_en;
    logic             w_psc_clr;
    logic             w_psc_en;

    // Leaving PAUSE with pause low counts on that same edge, so a pause of
    // N cycles delays the terminal count by exactly N cycles.
    assign w_step = !stop && !start && !pause &&
                    ((r_state == ST_RUN) || (r_state == ST_PAUSE));
    assign w_tick = (w_psc == r_prescale);
    assign w_term = w_step && w_tick && (w_count == r_period);

    assign w_cnt_clr = stop || start || (w_term && (r_mode == PERIODIC));
    assign w_cnt_en  = w_step && w_tick && !w_term;
    assign w_psc_clr = stop || start || (w_step && w_tick);
    assign w_psc_en  = w_step && !w_tick;

    up_counter_en #(.WIDTH(WIDTH)) u_count (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (w_cnt_clr),
        .en      (w_cnt_en),
        .q       (w_count)
    );

    up_counter_en #(.WIDTH(PSW)) u_prescaler (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (w_psc_clr),
        .en      (w_psc_en),
        .q       (w_psc)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_mode     <= ONE_SHOT;
            r_period   <= '0;
            r_prescale <= '0;
            r_tc       <= 1'b0;
            r_irq      <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_tc <= 1'b0;
            // Set wins over a simultaneous clear.
            if (w_term) begin
                r_irq <= 1'b1;
            end else if (irq_clr) begin
                r_irq <= 1'b0;
            end

            if (stop) begin
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
            end else if (start) begin
                r_mode     <= mode;
                r_period   <= period;
                r_prescale <= prescale;
                r_state    <= ST_RUN;
                r_busy     <= 1'b1;
            end else begin
                case (r_state)
                    ST_RUN, ST_PAUSE: begin
                        if (pause) begin
                            r_state <= ST_PAUSE;
                        end else if (w_term) begin
                            r_tc <= 1'b1;
                            if (r_mode == PERIODIC) begin
                                r_state <= ST_RUN;
                            end else begin
                                r_state <= ST_DONE;
                                r_busy  <= 1'b0;
                            end
                        end else begin
                            r_state <= ST_RUN;
                        end
                    end
                    default: begin
                        r_state <= r_state;
                    end
                endcase
            end
        end
    end

    assign count = w_count;
    assign busy  = r_busy;
    assign tc    = r_tc;
    assign irq   = r_irq;

endmodule
`default_nettype wire
